mont_mul_ctrl: RTL

Sequencing controller for the carry-save Montgomery datapath (`mpadder`). On a start request it runs the bit-serial Montgomery loop over all bits of operand A, then the chunked 5-cycle carry resolve, then chunked conditional-subtract passes. Each subtract pass ends on the datapath's finish flag. It owns every control input of the adder and the operand-select mux that feeds `in_a`.

---
 rtl/mont_mul_ctrl_if.sv | 24 ++
 rtl/mont_mul_ctrl.sv | 74 +++++++
 2 files changed

// File: rtl/mont_mul_ctrl_if.sv
// mont_mul_ctrl_if: control/status bundle between the Montgomery sequencer and its datapath side.
interface mont_mul_ctrl_if #(parameter int NBITS = 512);
  logic                     start;
  logic                     a_bit;
  logic                     c_zero;
  logic                     sub_done;
  logic [$clog2(NBITS)-1:0] bit_idx;
  logic [1:0]               op_sel;
  logic                     enable_c;
  logic                     shift;
  logic                     subtract;
  logic [3:0]               chunk;
  logic                     busy;
  logic                     done;
  logic                     err;
  modport master (
    output start, a_bit, c_zero, sub_done,
    input  bit_idx, op_sel, enable_c, shift, subtract, chunk, busy, done, err
  );
  modport slave (
    input  start, a_bit, c_zero, sub_done,
    output bit_idx, op_sel, enable_c, shift, subtract, chunk, busy, done, err
  );
endinterface

// File: rtl/mont_mul_ctrl.sv
// mont_mul_ctrl: sequences the bit-serial Montgomery loop, chunked carry resolve and subtract passes.
module mont_mul_ctrl #(
  parameter int NBITS   = 512,
  parameter int NCHUNK  = 5,
  parameter int MAX_SUB = 3
) (
  input logic            clk,
  input logic            resetn,
  mont_mul_ctrl_if.slave bus
);
  localparam int BW = $clog2(NBITS);
  localparam int PW = $clog2(MAX_SUB + 1);
  typedef enum logic [2:0] {IDLE, ADDB, REDUCE, RESOLVE, SUB, DONE} state_t;
  state_t          r_state, w_next;
  logic [BW-1:0]   r_bit_idx;
  logic [3:0]      r_chunk;
  logic [PW-1:0]   r_pass;
  logic            r_err;
  logic            w_last_bit, w_last_chunk, w_pass_max, w_chunked;
  assign w_last_bit   = r_bit_idx == BW'(NBITS - 1);
  assign w_last_chunk = r_chunk == 4'(NCHUNK - 1);
  assign w_pass_max   = r_pass >= PW'(MAX_SUB);
  assign w_chunked    = r_state == RESOLVE || r_state == SUB;
  // r_pass counts the pass in progress, so it is 1 throughout the first SUB pass
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_bit_idx <= '0;
      r_chunk   <= '0;
      r_pass    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.start) begin
        r_bit_idx <= '0;
        r_pass    <= '0;
        r_err     <= 1'b0;
      end
      if (r_state == REDUCE && !w_last_bit) r_bit_idx <= r_bit_idx + 1'b1;
      if (w_chunked) r_chunk <= w_last_chunk ? 4'd0 : r_chunk + 4'd1;
      if (r_state == RESOLVE && w_last_chunk) r_pass <= PW'(1);
      if (r_state == SUB && w_last_chunk && !bus.sub_done) begin
        if (w_pass_max) r_err <= 1'b1;
        else r_pass <= r_pass + 1'b1;
      end
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.start ? ADDB : IDLE;
      ADDB:    w_next = REDUCE;
      REDUCE:  w_next = w_last_bit ? RESOLVE : ADDB;
      RESOLVE: w_next = w_last_chunk ? SUB : RESOLVE;
      SUB:     w_next = (w_last_chunk && (bus.sub_done || w_pass_max)) ? DONE : SUB;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // chunk bit3 freezes the adder carry register outside resolve/subtract
  always_comb begin
    bus.bit_idx  = r_bit_idx;
    bus.enable_c = r_state == ADDB;
    bus.shift    = r_state == REDUCE;
    bus.subtract = r_state == SUB;
    bus.busy     = r_state != IDLE;
    bus.done     = r_state == DONE;
    bus.err      = r_err;
    bus.chunk    = w_chunked ? r_chunk : 4'd8;
    bus.op_sel   = r_state == ADDB   ? {1'b0, bus.a_bit} :
                   r_state == REDUCE ? (bus.c_zero ? 2'd2 : 2'd0) :
                   r_state == SUB    ? 2'd3 : 2'd0;
  end
endmodule
